// File: rtl/ddr_req_arbiter_if.sv
// Request/FIFO bundle between the four DDR users, the arbiter and the
// arbitration FIFO write port.
interface ddr_req_arbiter_if #(
   parameter int unsigned DDR_AW = 27,
   parameter int unsigned DDR_DW = 64,
   parameter int unsigned ARB_DW = 96
);
   logic [3:0]          req_valid;
   logic [3:0]          req_wr;
   logic [4*DDR_AW-1:0] req_addr;
   logic [4*DDR_DW-1:0] req_data;
   logic [3:0]          req_ack;
   logic                arbfifo_full;
   logic                arbfifo_wren;
   logic [ARB_DW-1:0]   arbfifo_wrdata;
   logic [1:0]          grant_id;
   logic                busy;

   modport slave (
      input  req_valid, req_wr, req_addr, req_data, arbfifo_full,
      output req_ack, arbfifo_wren, arbfifo_wrdata, grant_id, busy
   );

   modport master (
      output req_valid, req_wr, req_addr, req_data, arbfifo_full,
      input  req_ack, arbfifo_wren, arbfifo_wrdata, grant_id, busy
   );
endinterface

// File: rtl/ddr_req_arbiter.sv
// Round-robin DDR3 command arbiter for four requesters with bounded
// grant hold, packing each accepted request into one FIFO word.
module ddr_req_arbiter #(
   parameter int unsigned          CMD_WIDTH = 4,
   parameter int unsigned          DDR_DW    = 64,
   parameter int unsigned          DDR_AW    = 27,
   parameter int unsigned          ARB_DW    = 96,
   parameter int unsigned          GRANT_LEN = 8,
   parameter logic [CMD_WIDTH-1:0] CMD_RD    = 4'b0001,
   parameter logic [CMD_WIDTH-1:0] CMD_WR    = 4'b0010
) (
   input  logic               i_ddr_sclk,
   input  logic               i_rst_n,
   ddr_req_arbiter_if.slave   bus
);

   typedef enum logic {IDLE, SERVE} state_e;

   state_e            state_q, state_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [1:0]        grant_q, grant_d;
   logic [7:0]        beat_q, beat_d;
   logic              wren_q, wren_d;
   logic [ARB_DW-1:0] wrdata_q, wrdata_d;

   logic [3:0]        ack;
   logic [1:0]        pick, cand;
   logic              found;
   logic              g_valid, g_wr;
   logic [DDR_AW-1:0] g_addr;
   logic [DDR_DW-1:0] g_data;
   logic [ARB_DW-1:0] pack;

   assign g_valid = bus.req_valid[grant_q];
   assign g_wr    = bus.req_wr[grant_q];
   assign g_addr  = bus.req_addr[int'(grant_q)*DDR_AW +: DDR_AW];
   assign g_data  = bus.req_data[int'(grant_q)*DDR_DW +: DDR_DW];

   // First valid port strictly after the last served one.
   always_comb begin
      pick  = rr_ptr_q;
      found = 1'b0;
      cand  = rr_ptr_q;
      for (int k = 1; k <= 4; k++) begin
         cand = rr_ptr_q + 2'(k);
         if (!found && bus.req_valid[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      pack = '0;
      pack[DDR_DW-1:0] = g_wr ? g_data : '0;
      pack[DDR_DW +: DDR_AW] = g_addr;
      pack[DDR_DW+DDR_AW +: CMD_WIDTH] = g_wr ? CMD_WR : CMD_RD;
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      beat_d   = beat_q;
      wren_d   = 1'b0;
      wrdata_d = wrdata_q;
      ack      = '0;
      unique case (state_q)
         IDLE: begin
            if (found && !bus.arbfifo_full) begin
               grant_d = pick;
               beat_d  = '0;
               state_d = SERVE;
            end
         end
         SERVE: begin
            if (g_valid && !bus.arbfifo_full) begin
               ack[grant_q] = 1'b1;
               wren_d       = 1'b1;
               wrdata_d     = pack;
               beat_d       = beat_q + 8'd1;
            end
            if (!g_valid ||
                (!bus.arbfifo_full && beat_q == 8'(GRANT_LEN-1))) begin
               state_d  = IDLE;
               rr_ptr_d = grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_ddr_sclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= 2'd3;
         grant_q  <= 2'd0;
         beat_q   <= 8'd0;
         wren_q   <= 1'b0;
         wrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         beat_q   <= beat_d;
         wren_q   <= wren_d;
         wrdata_q <= wrdata_d;
      end
   end

   assign bus.req_ack        = ack;
   assign bus.arbfifo_wren   = wren_q;
   assign bus.arbfifo_wrdata = wrdata_q;
   assign bus.grant_id       = grant_q;
   assign bus.busy           = (state_q == SERVE);

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Randomised scoreboard bench for ddr_req_arbiter: a burst-level
// round-robin model predicts the FIFO word order.
module tb_ddr_req_arbiter;

   localparam int GL = 4;
   localparam int AW = 27;
   localparam int DW = 64;
   localparam int ADW = 96;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } req_t;

   typedef struct {
      logic [ADW-1:0] word;
      int             port;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   int   n_wr = 0;
   int   last_port = 0;

   req_t pq[4][$];
   exp_t sbq[$];

   logic [3:0]     prev_ack = '0;
   logic [ADW-1:0] last_wd = '0;

   ddr_req_arbiter_if #(.DDR_AW(AW), .DDR_DW(DW), .ARB_DW(ADW)) bus ();

   ddr_req_arbiter #(.GRANT_LEN(GL)) u_dut (
      .i_ddr_sclk (clk),
      .i_rst_n    (rst_n),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [ADW-1:0] word_of(req_t r);
      logic [ADW-1:0] w;
      w = '0;
      w[DW-1:0] = r.wr ? r.data : '0;
      w[DW +: AW] = r.addr;
      w[DW+AW +: 4] = r.wr ? 4'b0010 : 4'b0001;
      return w;
   endfunction

   function automatic int oh_idx(logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic req_t rnd_req();
      req_t r;
      r.wr   = 1'($urandom_range(0, 1));
      r.addr = AW'($urandom);
      r.data = {$urandom, $urandom};
      return r;
   endfunction

   // Burst-level model: next non-empty port after ptr, up to GL beats.
   task automatic build_expected(int start);
      req_t m[4][$];
      int   ptr, p, n;
      bit   any;
      for (int i = 0; i < 4; i++) m[i] = pq[i];
      ptr = start;
      forever begin
         any = 0;
         for (int i = 0; i < 4; i++) if (m[i].size() > 0) any = 1;
         if (!any) break;
         p = ptr;
         for (int k = 1; k <= 4; k++) begin
            if (m[(ptr + k) % 4].size() > 0) begin
               p = (ptr + k) % 4;
               break;
            end
         end
         n = 0;
         while (n < GL && m[p].size() > 0) begin
            sbq.push_back('{word_of(m[p].pop_front()), p});
            n++;
         end
         ptr = p;
      end
      last_port = ptr;
   endtask

   task automatic drive_inputs();
      for (int p = 0; p < 4; p++) begin
         bus.req_valid[p] = (pq[p].size() > 0);
         if (pq[p].size() > 0) begin
            bus.req_wr[p] = pq[p][0].wr;
            bus.req_addr[p*AW +: AW] = pq[p][0].addr;
            bus.req_data[p*DW +: DW] = pq[p][0].data;
         end else begin
            bus.req_wr[p] = 1'b0;
            bus.req_addr[p*AW +: AW] = '0;
            bus.req_data[p*DW +: DW] = '0;
         end
      end
   endtask

   task automatic step();
      logic [3:0] a, e;
      int g;
      @(negedge clk);
      a = bus.req_ack;
      g = int'(bus.grant_id);
      e = (bus.busy && bus.req_valid[g] && !bus.arbfifo_full) ?
          4'(1 << g) : 4'b0;
      chk("ack", 128'(a), 128'(e));
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++)
         if (a[p] && pq[p].size() > 0) void'(pq[p].pop_front());
      drive_inputs();
      bus.arbfifo_full = ($urandom_range(0, 3) == 0);
   endtask

   task automatic drain(string nm);
      bit busy_q;
      for (int c = 0; c < 3000; c++) begin
         busy_q = 0;
         for (int p = 0; p < 4; p++) if (pq[p].size() > 0) busy_q = 1;
         if (!busy_q && sbq.size() == 0) break;
         step();
      end
      repeat (3) step();
      chk({nm, "_left"}, 128'(sbq.size()), 128'(0));
      chk({nm, "_busy"}, 128'(bus.busy), 128'(0));
      chk({nm, "_grant"}, 128'(bus.grant_id), 128'(last_port));
   endtask

   task automatic check_zero(string nm);
      chk({nm, "_ack"}, 128'(bus.req_ack), 128'(0));
      chk({nm, "_wren"}, 128'(bus.arbfifo_wren), 128'(0));
      chk({nm, "_wrdata"}, 128'(bus.arbfifo_wrdata), 128'(0));
      chk({nm, "_grant"}, 128'(bus.grant_id), 128'(0));
      chk({nm, "_busy"}, 128'(bus.busy), 128'(0));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_ack = '0;
         last_wd = '0;
      end else begin
         chk("wren_latency", 128'(bus.arbfifo_wren), 128'(prev_ack != 0));
         if (bus.arbfifo_wren) begin
            n_wr++;
            if (sbq.size() == 0) begin
               chk("extra_word", 128'(bus.arbfifo_wrdata), 128'(0));
            end else begin
               e = sbq.pop_front();
               chk("word", 128'(bus.arbfifo_wrdata), 128'(e.word));
               chk("word_port", 128'(oh_idx(prev_ack)), 128'(e.port));
            end
         end else begin
            chk("wrdata_hold", 128'(bus.arbfifo_wrdata), 128'(last_wd));
         end
         last_wd = bus.arbfifo_wrdata;
         prev_ack = bus.req_ack;
      end
   end

   initial begin
      req_t r;
      rst_n = 1'b1;
      bus.req_valid = '0;
      bus.req_wr = '0;
      bus.req_addr = '0;
      bus.req_data = '0;
      bus.arbfifo_full = 1'b0;
      #1 rst_n = 1'b0;
      #3 check_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Phase 1: random traffic plus the directed packing cases.
      for (int p = 0; p < 4; p++) begin
         int n = $urandom_range(3, 10);
         for (int i = 0; i < n; i++) pq[p].push_back(rnd_req());
      end
      for (int i = 2; i >= 0; i--) begin
         r.wr = 1'b1;
         r.addr = AW'(27'h100 + i);
         r.data = 64'hA5A5_A5A5_A5A5_A5A5 + 64'(i);
         pq[2].push_front(r);
      end
      r.wr = 1'b0;
      r.addr = 27'h7FF_FFFF;
      r.data = '1;
      pq[3].push_front(r);
      build_expected(3);
      drive_inputs();
      drain("p1");

      // Phase 2: move rr_ptr off its reset value, then reset mid-grant.
      n_wr = 0;
      for (int i = 0; i < GL + 2; i++) pq[1].push_back(rnd_req());
      for (int i = 0; i < 6; i++) pq[2].push_back(rnd_req());
      build_expected(last_port);
      drive_inputs();
      for (int c = 0; c < 2000 && n_wr < GL + 1; c++) step();
      chk("p2_reach", 128'(n_wr >= GL + 1), 128'(1));
      #2 rst_n = 1'b0;
      #1 check_zero("midreset");
      sbq.delete();
      for (int p = 0; p < 4; p++) pq[p].delete();
      drive_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Phase 3: rr_ptr must be back at 3, so port 0 leads.
      for (int p = 0; p < 4; p++) begin
         int n = $urandom_range(2, 6);
         for (int i = 0; i < n; i++) pq[p].push_back(rnd_req());
      end
      build_expected(3);
      chk("p3_first_port", 128'(sbq[0].port), 128'(0));
      drive_inputs();
      drain("p3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
